jtdsp16_rom_arb: RTL and testbench

- Arbitrates the single program-memory port between instruction fetch (the ROM address unit's PC) and table reads (PT-addressed coefficient lookups).
- Inserts programmable wait states for external memory.
- Stalls the address unit through pc_halt while the port is busy or a fetch has not finished.
- Sits between the ROM address unit/sequencer and the ROM/external-memory bus.

---
 rtl/jtdsp16_rom_arb.sv | 155 +++++++++++++++
 tb/tb_jtdsp16_rom_arb.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtdsp16_rom_arb.sv
// -----------------------------------------------------------------------------
// jtdsp16_rom_arb
//
// Shares the single program-memory port between instruction fetch (driven by
// the PC of the ROM address unit) and table reads (PT-addressed coefficient
// lookups). External addresses get a programmable number of wait states.
// The address unit is stalled through pc_halt while a table read owns the
// port or while a fetch is still waiting for its data.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   cen          clock enable; every register advances only when cen=1
//   fetch_addr   instruction address (PC)
//   tbl_req      table read request, held high until tbl_ack
//   tbl_addr     table address, stable while tbl_req=1
//   wait_cfg     wait states applied to external accesses (0..15)
//   mem_din      memory read data
//   mem_addr     memory address, combinational from state
//   mem_cs       memory select, the port is always busy with some access
//   pc_halt      combinational stall to the address unit
//   instr_dout   last fetched instruction (registered)
//   instr_valid  one-cen pulse: instr_dout was updated
//   tbl_dout     last table read data (registered)
//   tbl_ack      one-cen pulse: tbl_dout was updated
// -----------------------------------------------------------------------------
module jtdsp16_rom_arb #(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int INT_AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic [AW-1:0] fetch_addr,
    input  logic          tbl_req,
    input  logic [AW-1:0] tbl_addr,
    input  logic [3:0]    wait_cfg,
    input  logic [DW-1:0] mem_din,
    output logic [AW-1:0] mem_addr,
    output logic          mem_cs,
    output logic          pc_halt,
    output logic [DW-1:0] instr_dout,
    output logic          instr_valid,
    output logic [DW-1:0] tbl_dout,
    output logic          tbl_ack
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_TBL   = 1'b1
    } state_t;

    state_t        state, state_nx;
    logic [3:0]    wcnt, wcnt_nx;      // wait cycles already spent on this access
    logic [3:0]    wlat, wlat_nx;      // wait count latched at the start of the access
    logic [DW-1:0] instr_nx, tbl_nx;
    logic          instr_valid_nx, tbl_ack_nx;

    logic          is_ext;             // current access address lies outside the internal ROM
    logic [3:0]    fresh_w;            // wait count the access would get if it started now
    logic [3:0]    eff_w;              // wait count that governs completion this cycle
    logic          access_done;
    logic          tbl_grant;

    // The port serves exactly one requester at a time, selected by state.
    always_comb begin
        mem_addr = (state == S_TBL) ? tbl_addr : fetch_addr;
    end

    assign mem_cs  = 1'b1;
    assign is_ext  = |mem_addr[AW-1:INT_AW];
    assign fresh_w = is_ext ? wait_cfg : 4'd0;

    // On the first cycle of an access wlat still holds the previous access's
    // value, so completion must be judged against the freshly computed count.
    assign eff_w       = (wcnt == 4'd0) ? fresh_w : wlat;
    assign access_done = (wcnt == eff_w);

    // A table request is only granted between fetches; it never interrupts one.
    assign tbl_grant = (state == S_FETCH) && (wcnt == 4'd0) && tbl_req;

    // Next-state and output decode.
    // NOTE: every signal written here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_nx       = state;
        wcnt_nx        = wcnt;
        wlat_nx        = wlat;
        instr_nx       = instr_dout;
        tbl_nx         = tbl_dout;
        instr_valid_nx = 1'b0;
        tbl_ack_nx     = 1'b0;
        pc_halt        = 1'b1;

        // Freeze the wait count for the whole access so wait_cfg edits
        // only take effect on the next one.
        if (wcnt == 4'd0) begin
            wlat_nx = fresh_w;
        end

        unique case (state)
            S_FETCH: begin
                if (tbl_grant) begin
                    state_nx = S_TBL;
                    wcnt_nx  = 4'd0;
                end else if (access_done) begin
                    instr_nx       = mem_din;
                    instr_valid_nx = 1'b1;
                    wcnt_nx        = 4'd0;
                    pc_halt        = 1'b0;
                end else begin
                    wcnt_nx = wcnt + 4'd1;
                end
            end

            S_TBL: begin
                // pc_halt stays at its default of 1 for the whole table read.
                if (access_done) begin
                    tbl_nx     = mem_din;
                    tbl_ack_nx = 1'b1;
                    wcnt_nx    = 4'd0;
                    state_nx   = S_FETCH;
                end else begin
                    wcnt_nx = wcnt + 4'd1;
                end
            end
        endcase
    end

    // State register. Reset wins over cen so an access in flight is dropped
    // without producing a pulse.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            wcnt        <= 4'd0;
            wlat        <= 4'd0;
            instr_dout  <= '0;
            tbl_dout    <= '0;
            instr_valid <= 1'b0;
            tbl_ack     <= 1'b0;
        end else if (cen) begin
            state       <= state_nx;
            wcnt        <= wcnt_nx;
            wlat        <= wlat_nx;
            instr_dout  <= instr_nx;
            tbl_dout    <= tbl_nx;
            instr_valid <= instr_valid_nx;
            tbl_ack     <= tbl_ack_nx;
        end
    end

endmodule

// File: tb/tb_jtdsp16_rom_arb.sv
// -----------------------------------------------------------------------------
// tb_jtdsp16_rom_arb
//
// Self-checking bench for jtdsp16_rom_arb. A behavioural model tracks which
// requester owns the port and how many wait cycles remain on the current
// access (a countdown set from the address class when the access begins).
// Directed vectors carry hand-derived expectations; multi-cycle corner cases
// are hand-written sequences; a randomized phase runs against the model.
// -----------------------------------------------------------------------------
module tb_jtdsp16_rom_arb;

    localparam int AW     = 16;
    localparam int DW     = 16;
    localparam int INT_AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          cen;
    logic [AW-1:0] fetch_addr;
    logic          tbl_req;
    logic [AW-1:0] tbl_addr;
    logic [3:0]    wait_cfg;
    logic [DW-1:0] mem_din;
    logic [AW-1:0] mem_addr;
    logic          mem_cs;
    logic          pc_halt;
    logic [DW-1:0] instr_dout;
    logic          instr_valid;
    logic [DW-1:0] tbl_dout;
    logic          tbl_ack;

    jtdsp16_rom_arb #(.AW(AW), .DW(DW), .INT_AW(INT_AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cen         (cen),
        .fetch_addr  (fetch_addr),
        .tbl_req     (tbl_req),
        .tbl_addr    (tbl_addr),
        .wait_cfg    (wait_cfg),
        .mem_din     (mem_din),
        .mem_addr    (mem_addr),
        .mem_cs      (mem_cs),
        .pc_halt     (pc_halt),
        .instr_dout  (instr_dout),
        .instr_valid (instr_valid),
        .tbl_dout    (tbl_dout),
        .tbl_ack     (tbl_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            m_init = 1'b0;  // model is meaningful once a reset edge was seen
    bit            m_tbl  = 1'b0;  // table read owns the port
    bit            m_busy = 1'b0;  // an access has started and its wait count is fixed
    int            m_left = 0;     // wait cycles still to go once busy
    logic [DW-1:0] m_instr = '0;
    logic [DW-1:0] m_tdata = '0;
    bit            m_iv  = 1'b0;
    bit            m_ack = 1'b0;

    function automatic bit external(input logic [AW-1:0] a);
        return a >= (1 << INT_AW);
    endfunction

    task automatic model_comb(output logic [AW-1:0] a, output logic h,
                              output logic g, output logic d, output int left);
        a    = m_tbl ? tbl_addr : fetch_addr;
        left = m_busy ? m_left : (external(a) ? int'(wait_cfg) : 0);
        g    = !m_tbl && !m_busy && tbl_req;
        d    = !g && (left == 0);
        h    = m_tbl || g || !d;
    endtask

    task automatic model_update(input logic r, input logic c, input logic g,
                                input logic d, input int left);
        if (r) begin
            m_tbl = 0; m_busy = 0; m_left = 0;
            m_instr = '0; m_tdata = '0; m_iv = 0; m_ack = 0;
        end else if (c) begin
            m_iv  = 0;
            m_ack = 0;
            if (g) begin
                m_tbl  = 1;
                m_busy = 0;
            end else if (d) begin
                m_busy = 0;
                if (m_tbl) begin
                    m_tdata = mem_din;
                    m_ack   = 1;
                    m_tbl   = 0;
                end else begin
                    m_instr = mem_din;
                    m_iv    = 1;
                end
            end else begin
                m_busy = 1;
                m_left = left - 1;
            end
        end
    endtask

    logic          last_halt;
    logic [AW-1:0] last_addr;

    // One clock: drive inputs, check combinational outputs before the edge,
    // clock, then check registered outputs after the edge. Called at negedge.
    task automatic step(input logic r, input logic c, input logic [AW-1:0] fa,
                        input logic tr, input logic [AW-1:0] ta,
                        input logic [3:0] wc, input logic [DW-1:0] din);
        logic [AW-1:0] ea;
        logic          eh, g, d;
        int            left;
        rst = r; cen = c; fetch_addr = fa; tbl_req = tr;
        tbl_addr = ta; wait_cfg = wc; mem_din = din;
        #1;
        model_comb(ea, eh, g, d, left);
        last_halt = pc_halt;
        last_addr = mem_addr;
        if (m_init) begin
            check("mem_addr", 32'(mem_addr), 32'(ea));
            check("pc_halt", 32'(pc_halt), 32'(eh));
            check("mem_cs", 32'(mem_cs), 32'd1);
        end
        @(posedge clk);
        #1;
        model_update(r, c, g, d, left);
        if (r) m_init = 1'b1;
        if (m_init) begin
            check("instr_valid", 32'(instr_valid), 32'(m_iv));
            check("tbl_ack", 32'(tbl_ack), 32'(m_ack));
            check("instr_dout", 32'(instr_dout), 32'(m_instr));
            check("tbl_dout", 32'(tbl_dout), 32'(m_tdata));
            check("pulse_excl", 32'(instr_valid & tbl_ack), 32'd0);
        end
        @(negedge clk);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic          r, c;
        logic [AW-1:0] fa;
        logic          tr;
        logic [AW-1:0] ta;
        logic [3:0]    wc;
        logic [DW-1:0] din;
        logic          cc;      // compare combinational outputs of this row
        logic [AW-1:0] e_addr;
        logic          e_halt;
        logic          e_iv, e_ack;
        logic [DW-1:0] e_instr, e_tbl;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_halt, n_iv, iv_idx, ack_idx;
        logic tr4;
        logic rr, rc, rtr;
        logic [AW-1:0] rta, rfa;

        rst = 1'b1; cen = 1'b0; fetch_addr = '0; tbl_req = 1'b0;
        tbl_addr = '0; wait_cfg = '0; mem_din = '0;

        //           r  c  fa       tr ta       wc din      cc addr     h  iv ack instr    tbl
        vecs[0]  = '{1, 1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000};
        vecs[1]  = '{1, 1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000};
        vecs[2]  = '{0, 1, 16'h0000, 0, 16'h0000, 0, 16'hA000, 1, 16'h0000, 0, 1, 0, 16'hA000, 16'h0000};
        vecs[3]  = '{0, 1, 16'h0001, 0, 16'h0000, 0, 16'hA001, 1, 16'h0001, 0, 1, 0, 16'hA001, 16'h0000};
        vecs[4]  = '{0, 1, 16'h0002, 0, 16'h0000, 0, 16'hA002, 1, 16'h0002, 0, 1, 0, 16'hA002, 16'h0000};
        vecs[5]  = '{0, 1, 16'h0003, 0, 16'h0000, 0, 16'hA003, 1, 16'h0003, 0, 1, 0, 16'hA003, 16'h0000};
        vecs[6]  = '{0, 1, 16'h0004, 0, 16'h0000, 0, 16'hA004, 1, 16'h0004, 0, 1, 0, 16'hA004, 16'h0000};
        vecs[7]  = '{0, 1, 16'h0005, 1, 16'h2345, 2, 16'hB000, 1, 16'h0005, 1, 0, 0, 16'hA004, 16'h0000};
        vecs[8]  = '{0, 1, 16'h0005, 1, 16'h2345, 2, 16'hB001, 1, 16'h2345, 1, 0, 0, 16'hA004, 16'h0000};
        vecs[9]  = '{0, 1, 16'h0005, 1, 16'h2345, 2, 16'hB002, 1, 16'h2345, 1, 0, 0, 16'hA004, 16'h0000};
        vecs[10] = '{0, 1, 16'h0005, 1, 16'h2345, 2, 16'hBEEF, 1, 16'h2345, 1, 0, 1, 16'hA004, 16'hBEEF};
        vecs[11] = '{0, 1, 16'h0005, 0, 16'h0000, 2, 16'hA005, 1, 16'h0005, 0, 1, 0, 16'hA005, 16'hBEEF};

        @(negedge clk);

        // Reset, internal fetch stream, table read from an internal fetch.
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].r, vecs[i].c, vecs[i].fa, vecs[i].tr, vecs[i].ta,
                 vecs[i].wc, vecs[i].din);
            if (vecs[i].cc) begin
                check($sformatf("vec%0d_addr", i), 32'(last_addr), 32'(vecs[i].e_addr));
                check($sformatf("vec%0d_halt", i), 32'(last_halt), 32'(vecs[i].e_halt));
            end
            check($sformatf("vec%0d_iv", i), 32'(instr_valid), 32'(vecs[i].e_iv));
            check($sformatf("vec%0d_ack", i), 32'(tbl_ack), 32'(vecs[i].e_ack));
            check($sformatf("vec%0d_instr", i), 32'(instr_dout), 32'(vecs[i].e_instr));
            check($sformatf("vec%0d_tbl", i), 32'(tbl_dout), 32'(vecs[i].e_tbl));
        end

        // External fetch, 3 wait states: 3 halted cens, data on the 4th.
        n_halt = 0; n_iv = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 16'h1000, 0, 16'h0000, 4'd3, 16'hC000 + 16'(i));
            n_halt += int'(last_halt);
            n_iv   += int'(instr_valid);
        end
        check("t2_halt_cnt", 32'(n_halt), 32'd3);
        check("t2_iv_cnt", 32'(n_iv), 32'd1);
        check("t2_instr", 32'(instr_dout), 32'h0000C003);

        // Table request raised at wcnt=2 of a 5-wait fetch: fetch finishes first.
        iv_idx = -1; ack_idx = -1; tr4 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) tr4 = 1'b1;
            if (ack_idx >= 0) tr4 = 1'b0;
            step(0, 1, (ack_idx >= 0) ? 16'h0020 : 16'h1000, tr4, 16'h0010, 4'd5,
                 16'hD000 + 16'(i));
            if (instr_valid && iv_idx < 0) iv_idx = i;
            if (tbl_ack && ack_idx < 0) ack_idx = i;
        end
        check("t4_iv_idx", 32'(iv_idx), 32'd5);
        check("t4_ack_idx", 32'(ack_idx), 32'd7);
        check("t4_tbl", 32'(tbl_dout), 32'h0000D007);

        // cen gaps during a 2-wait access; wait_cfg edit applies to the next access.
        step(0, 1, 16'h1000, 0, 16'h0000, 4'd2, 16'hE000);
        step(0, 0, 16'h1000, 0, 16'h0000, 4'd2, 16'hE001);
        check("t5_halt_gap", 32'(last_halt), 32'd1);
        step(0, 1, 16'h1000, 0, 16'h0000, 4'd7, 16'hE002);
        check("t5_iv_early", 32'(instr_valid), 32'd0);
        step(0, 0, 16'h1000, 0, 16'h0000, 4'd7, 16'hE003);
        step(0, 1, 16'h1000, 0, 16'h0000, 4'd7, 16'hE004);
        check("t5_iv_done", 32'(instr_valid), 32'd1);
        check("t5_instr", 32'(instr_dout), 32'h0000E004);
        step(0, 0, 16'h1000, 0, 16'h0000, 4'd7, 16'hE005);
        check("t5_iv_hold", 32'(instr_valid), 32'd1);
        n_halt = 0; n_iv = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 16'h1001, 0, 16'h0000, 4'd7, 16'hE100 + 16'(i));
            n_halt += int'(last_halt);
            n_iv   += int'(instr_valid);
        end
        check("t5_halt_cnt7", 32'(n_halt), 32'd7);
        check("t5_iv_cnt7", 32'(n_iv), 32'd1);
        check("t5_instr7", 32'(instr_dout), 32'h0000E107);

        // Reset in the middle of a table read.
        step(0, 1, 16'h0006, 1, 16'h2345, 4'd3, 16'hF000);
        step(0, 1, 16'h0006, 1, 16'h2345, 4'd3, 16'hF001);
        step(1, 1, 16'h0006, 1, 16'h2345, 4'd3, 16'hF002);
        check("t6_ack", 32'(tbl_ack), 32'd0);
        check("t6_tbl", 32'(tbl_dout), 32'd0);
        check("t6_instr", 32'(instr_dout), 32'd0);
        check("t6_iv", 32'(instr_valid), 32'd0);
        step(0, 1, 16'h0007, 0, 16'h0000, 4'd3, 16'hF003);
        check("t6_addr", 32'(last_addr), 32'h00000007);
        check("t6_halt", 32'(last_halt), 32'd0);

        // Randomized traffic against the model.
        rtr = 1'b0; rta = '0; rfa = 16'h0030;
        for (int i = 0; i < 800; i++) begin
            rr = ($urandom_range(0, 99) == 0);
            rc = ($urandom_range(0, 3) != 0);
            if (tbl_ack && $urandom_range(0, 3) != 0) begin
                rtr = 1'b0;
            end else if (!rtr && $urandom_range(0, 5) == 0) begin
                rtr = 1'b1;
                rta = $urandom_range(0, 1) ? {4'h0, 12'($urandom)} : 16'($urandom);
            end
            if (!m_busy && !m_tbl)
                rfa = ($urandom_range(0, 2) != 0) ? {4'h0, 12'($urandom)} : 16'($urandom);
            step(rr, rc, rfa, rtr, rta, 4'($urandom_range(0, 3)), 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
